countdown_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit synchronous down counter among NREQ requesters. A granted requester's load value is captured, counted down on each tick, and completion is signalled back to that requester with a one-cycle done pulse. The block sits between timer clients (debouncers, delay generators) and the shared down-counter datapath, and owns its load, enable and terminal-count sequencing.

---
 rtl/countdown_share_arbiter.sv | 135 +++++++++++++
 tb/tb_countdown_share_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_share_arbiter.sv
// Round-robin arbiter that lends one shared down counter to NREQ timer clients.
// The winner's load value is captured at grant, counted down on tick, and completion is pulsed back.
module countdown_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] load_val,
    input  logic                  tick,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic                  abort
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t           r_state, w_state_next;
    logic [NREQ-1:0]  r_gnt, w_gnt_next;
    logic [NREQ-1:0]  r_done, w_done_next;
    logic [WIDTH-1:0] r_count, w_count_next;
    logic             r_abort, w_abort_next;
    logic [LW-1:0]    r_last, w_last_next;

    logic [WIDTH-1:0] w_load [NREQ];
    logic             w_pick_valid;
    logic [LW-1:0]    w_pick_idx;
    int               w_cand;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_load
            assign w_load[gi] = load_val[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the farthest candidate back to last+1 so the nearest set bit wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = int'(r_last) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (req[w_cand[LW-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand[LW-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_done_next  = '0;
        w_count_next = r_count;
        w_abort_next = 1'b0;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                w_gnt_next = '0;
                if (w_pick_valid) begin
                    w_gnt_next[w_pick_idx] = 1'b1;
                    w_last_next            = w_pick_idx;
                    w_count_next           = w_load[w_pick_idx];
                    if (w_load[w_pick_idx] == '0) begin
                        w_state_next            = ST_DONE;
                        w_done_next[w_pick_idx] = 1'b1;
                    end else begin
                        w_state_next = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                // A withdrawn request takes precedence over a tick on the same edge.
                if ((req & r_gnt) == '0) begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = '0;
                    w_count_next = '0;
                    w_abort_next = 1'b1;
                end else if (tick && (r_count != '0)) begin
                    w_count_next = r_count - 1'b1;
                    if (r_count == WIDTH'(1)) begin
                        w_state_next = ST_DONE;
                        w_done_next  = r_gnt;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_abort <= 1'b0;
            r_last  <= LW'(NREQ - 1);
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_count <= w_count_next;
            r_abort <= w_abort_next;
            r_last  <= w_last_next;
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign count = r_count;
    assign abort = r_abort;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_countdown_share_arbiter.sv
// Bench for countdown_share_arbiter: fixed vector table, directed multi-cycle
// sequences, then biased random traffic checked against an owner/remaining-count model.
module tb_countdown_share_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] load_val = '0;
    logic                  tick = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic                  abort;

    countdown_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
        .tick     (tick),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .count    (count),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: who owns the counter, how much is left, and whether
    // the completion cycle is being shown.
    int m_owner;
    int m_left;
    int m_last;
    bit m_fin;
    bit m_abort;
    bit model_on = 1'b0;

    function void model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = NREQ - 1;
        m_fin   = 1'b0;
        m_abort = 1'b0;
    endfunction

    function void model_step();
        m_abort = 1'b0;
        if (m_fin) begin
            m_fin   = 1'b0;
            m_owner = -1;
            m_left  = 0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                int j;
                j = (m_last + i) % NREQ;
                if (req[j]) begin
                    m_owner = j;
                    m_last  = j;
                    m_left  = int'(load_val[j*WIDTH +: WIDTH]);
                    m_fin   = (m_left == 0);
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_abort = 1'b1;
            m_owner = -1;
            m_left  = 0;
        end else if (tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_fin = 1'b1;
        end
    endfunction

    function automatic logic [31:0] model_gnt();
        return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    task automatic compare_model();
        chk("rnd_gnt",   32'(gnt),   model_gnt());
        chk("rnd_done",  32'(done),  m_fin ? model_gnt() : 32'd0);
        chk("rnd_count", 32'(count), 32'(m_left));
        chk("rnd_busy",  32'(busy),  32'(m_owner >= 0));
        chk("rnd_abort", 32'(abort), 32'(m_abort));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (model_on) compare_model();
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        tick     = 1'b0;
        load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int b = 0; b < NREQ; b++) if (v[b]) r = b;
        return r;
    endfunction

    typedef struct {
        logic [NREQ-1:0]       req;
        logic [NREQ*WIDTH-1:0] ld;
        logic                  tick;
        logic [NREQ-1:0]       gnt;
        logic [NREQ-1:0]       done;
        logic [WIDTH-1:0]      cnt;
        logic                  busy;
        logic                  abort;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int grants [$];
        int n_done;
        int exp_cnt;
        int c_done;
        logic [NREQ-1:0] prev_gnt;

        //          req      ld        tk  gnt      done     cnt busy abort
        tbl[0]  = '{4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 3, 1, 0};
        tbl[1]  = '{4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 2, 1, 0};
        tbl[2]  = '{4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 1, 1, 0};
        tbl[3]  = '{4'b0001, 16'h0003, 1, 4'b0001, 4'b0001, 0, 1, 0};
        tbl[4]  = '{4'b0000, 16'h0003, 1, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[5]  = '{4'b0100, 16'h0000, 1, 4'b0100, 4'b0100, 0, 1, 0};
        tbl[6]  = '{4'b0100, 16'h0000, 1, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[7]  = '{4'b0000, 16'h0000, 1, 4'b0000, 4'b0000, 0, 0, 0};
        tbl[8]  = '{4'b1000, 16'h2000, 0, 4'b1000, 4'b0000, 2, 1, 0};
        tbl[9]  = '{4'b1000, 16'h2000, 0, 4'b1000, 4'b0000, 2, 1, 0};
        tbl[10] = '{4'b1000, 16'h2000, 1, 4'b1000, 4'b0000, 1, 1, 0};
        tbl[11] = '{4'b0111, 16'h2000, 1, 4'b0000, 4'b0000, 0, 0, 1};
        tbl[12] = '{4'b0111, 16'h2000, 1, 4'b0001, 4'b0001, 0, 1, 0};
        tbl[13] = '{4'b0000, 16'h2000, 1, 4'b0000, 4'b0000, 0, 0, 0};

        // Reset state, then still idle after release with no requests.
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        rst = 1'b1;
        cycle();
        chk("idle_gnt",  32'(gnt),  32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 14; v++) begin
            req      = tbl[v].req;
            load_val = tbl[v].ld;
            tick     = tbl[v].tick;
            cycle();
            $display("vec %0d req=%b tick=%b -> gnt=%b done=%b count=%0d busy=%b abort=%b",
                     v, req, tick, gnt, done, count, busy, abort);
            chk($sformatf("vec%0d_gnt", v),   32'(gnt),   32'(tbl[v].gnt));
            chk($sformatf("vec%0d_done", v),  32'(done),  32'(tbl[v].done));
            chk($sformatf("vec%0d_count", v), 32'(count), 32'(tbl[v].cnt));
            chk($sformatf("vec%0d_busy", v),  32'(busy),  32'(tbl[v].busy));
            chk($sformatf("vec%0d_abort", v), 32'(abort), 32'(tbl[v].abort));
        end

        // All four requesting with load 1: strict rotation 0,1,2,3,0.
        do_reset();
        req      = 4'b1111;
        load_val = 16'h1111;
        tick     = 1'b1;
        n_done   = 0;
        prev_gnt = '0;
        for (int c = 0; c < 15; c++) begin
            cycle();
            if (gnt != '0 && prev_gnt == '0) grants.push_back(onehot_idx(gnt));
            if (done != '0) n_done++;
            prev_gnt = gnt;
        end
        $display("rotation: %0d grants, %0d done pulses", grants.size(), n_done);
        chk("rr_ngrants", 32'(grants.size()), 32'd5);
        chk("rr_ndone",   32'(n_done),        32'd5);
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rr_order%0d", g),
                (g < grants.size()) ? 32'(grants[g]) : 32'hFFFF_FFFF, 32'(g % NREQ));
        end

        // Load 5 with tick alternating: decrement only on tick edges.
        do_reset();
        req      = 4'b0001;
        load_val = 16'h0005;
        tick     = 1'b1;
        cycle();
        chk("tk_gnt",   32'(gnt),   32'b0001);
        chk("tk_count", 32'(count), 32'd5);
        exp_cnt = 5;
        c_done  = -1;
        for (int c = 0; c < 20; c++) begin
            tick = (c % 2 == 0);
            cycle();
            if (tick) exp_cnt--;
            chk($sformatf("tk_count_c%0d", c), 32'(count), 32'(exp_cnt));
            chk($sformatf("tk_done_c%0d", c),  32'(done),  (exp_cnt == 0) ? 32'b0001 : 32'd0);
            if (exp_cnt == 0) begin
                c_done = c;
                break;
            end
        end
        chk("tk_done_cycle", 32'(c_done), 32'd8);
        cycle();
        chk("tk_gnt_drop", 32'(gnt), 32'd0);
        $display("tick-gated count finished at cycle %0d after grant", c_done + 1);

        // Cancel: req1 withdrawn at count 3, pending req2 granted next.
        do_reset();
        req      = 4'b0110;
        load_val = 16'h0260;
        tick     = 1'b1;
        cycle();
        chk("cx_gnt",   32'(gnt),   32'b0010);
        chk("cx_count", 32'(count), 32'd6);
        repeat (3) cycle();
        chk("cx_count3", 32'(count), 32'd3);
        req = 4'b0100;
        cycle();
        chk("cx_abort", 32'(abort), 32'd1);
        chk("cx_gnt0",  32'(gnt),   32'd0);
        chk("cx_cnt0",  32'(count), 32'd0);
        chk("cx_done0", 32'(done),  32'd0);
        chk("cx_busy0", 32'(busy),  32'd0);
        cycle();
        chk("cx_abort_clr", 32'(abort), 32'd0);
        chk("cx_next_gnt",  32'(gnt),   32'b0100);
        chk("cx_next_cnt",  32'(count), 32'd2);
        $display("cancel: abort seen, next grant=%b count=%0d", gnt, count);

        // Asynchronous reset in mid-count takes effect without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("ar_gnt",   32'(gnt),   32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_busy",  32'(busy),  32'd0);
        chk("ar_done",  32'(done),  32'd0);
        $display("async reset mid-count: gnt=%b count=%0d busy=%b", gnt, count, busy);

        // Biased random traffic against the model.
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if (req[b]) begin
                    if (done[b] || $urandom_range(0, 39) == 0) req[b] = 1'b0;
                end else if ($urandom_range(0, 4) == 0) begin
                    req[b] = 1'b1;
                end
            end
            load_val = NREQ*WIDTH'($urandom);
            tick     = ($urandom_range(0, 3) != 0);
            cycle();
            if (done != '0 || abort)
                $display("rnd cycle %0d: gnt=%b done=%b abort=%b", c, gnt, done, abort);
        end
        model_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
